// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and helpers for the ALU request sequencer.
// The ALU command codes live here so the ALU itself can import the same values.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_MP0 = 3'd3;
    localparam logic [2:0] ALU_MP1 = 3'd4;
    localparam logic [2:0] ALU_DV0 = 3'd5;
    localparam logic [2:0] ALU_DV1 = 3'd6;

    localparam logic [14:0] ERR_WORD = 15'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE1 = 2'd1,
        ST_ISSUE2 = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The ALU sees operands as 16-bit words with the value in bits 15:1.
    function automatic logic [15:0] packOperand(input logic [14:0] operand);
        return {operand, 1'b0};
    endfunction

    function automatic logic isTwoPhase(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic isErrorRequest(input logic [2:0] op, input logic [14:0] b);
        return (op > OP_DIV) || ((op == OP_DIV) && (b == 15'd0));
    endfunction

    function automatic logic [2:0] firstCommand(input logic [2:0] op);
        logic [2:0] cmd;
        case (op)
            OP_ADD:  cmd = ALU_ADD;
            OP_SUB:  cmd = ALU_SUB;
            OP_AND:  cmd = ALU_AND;
            OP_MUL:  cmd = ALU_MP0;
            OP_DIV:  cmd = ALU_DV0;
            default: cmd = ALU_ADD;
        endcase
        return cmd;
    endfunction

    function automatic logic [2:0] secondCommand(input logic [2:0] op);
        return (op == OP_MUL) ? ALU_MP1 : ALU_DV1;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-side signals of the sequencer bundled in one interface.
// The slave modport is the sequencer; the master modport is its surroundings.
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [14:0] req_a;
    logic [14:0] req_b;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [14:0] rsp_hi;
    logic [14:0] rsp_lo;
    logic        rsp_err;

    logic [2:0]  alu_command;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [14:0] alu_result;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
               alu_command, alu_a, alu_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err,
               alu_command, alu_a, alu_b
    );

endinterface

// File: rtl/alu_sequencer.sv
// Sequences one or two ALU commands per request, waits out the ALU settle time
// and returns the captured result words over a valid/ready response channel.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_WAIT = 2
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);

    localparam int CW = $clog2(ALU_WAIT + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(ALU_WAIT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [14:0]   r_rspHi;
    logic [14:0]   r_rspLo;
    logic          r_rspErr;
    logic [2:0]    r_aluCmd;
    logic [15:0]   r_aluA;
    logic [15:0]   r_aluB;

    state_t        w_nextState;
    logic [CW-1:0] w_cnt;
    logic [2:0]    w_op;
    logic [14:0]   w_rspHi;
    logic [14:0]   w_rspLo;
    logic          w_rspErr;
    logic [2:0]    w_aluCmd;
    logic [15:0]   w_aluA;
    logic [15:0]   w_aluB;
    logic          w_lastEdge;

    assign w_lastEdge = (r_cnt == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_ADD;
            r_rspHi  <= '0;
            r_rspLo  <= '0;
            r_rspErr <= 1'b0;
            r_aluCmd <= ALU_ADD;
            r_aluA   <= '0;
            r_aluB   <= '0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_cnt;
            r_op     <= w_op;
            r_rspHi  <= w_rspHi;
            r_rspLo  <= w_rspLo;
            r_rspErr <= w_rspErr;
            r_aluCmd <= w_aluCmd;
            r_aluA   <= w_aluA;
            r_aluB   <= w_aluB;
        end
    end

    // Error requests bypass the ALU entirely so its inputs keep their last command.
    always_comb begin
        w_nextState = r_state;
        w_cnt       = r_cnt;
        w_op        = r_op;
        w_rspHi     = r_rspHi;
        w_rspLo     = r_rspLo;
        w_rspErr    = r_rspErr;
        w_aluCmd    = r_aluCmd;
        w_aluA      = r_aluA;
        w_aluB      = r_aluB;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_op = bus.req_op;
                    if (isErrorRequest(bus.req_op, bus.req_b)) begin
                        w_rspHi     = ERR_WORD;
                        w_rspLo     = ERR_WORD;
                        w_rspErr    = 1'b1;
                        w_nextState = ST_RESP;
                    end else begin
                        w_aluCmd    = firstCommand(bus.req_op);
                        w_aluA      = packOperand(bus.req_a);
                        w_aluB      = packOperand(bus.req_b);
                        w_cnt       = '0;
                        w_rspHi     = '0;
                        w_rspLo     = '0;
                        w_rspErr    = 1'b0;
                        w_nextState = ST_ISSUE1;
                    end
                end
            end

            ST_ISSUE1: begin
                if (w_lastEdge) begin
                    w_cnt = '0;
                    if (isTwoPhase(r_op)) begin
                        w_rspHi     = bus.alu_result;
                        w_aluCmd    = secondCommand(r_op);
                        w_nextState = ST_ISSUE2;
                    end else begin
                        w_rspLo     = bus.alu_result;
                        w_nextState = ST_RESP;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_ISSUE2: begin
                if (w_lastEdge) begin
                    w_cnt       = '0;
                    w_rspLo     = bus.alu_result;
                    w_nextState = ST_RESP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_nextState = ST_IDLE;
                end
            end

            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.rsp_valid   = (r_state == ST_RESP);
    assign bus.rsp_hi      = r_rspHi;
    assign bus.rsp_lo      = r_rspLo;
    assign bus.rsp_err     = r_rspErr;
    assign bus.alu_command = r_aluCmd;
    assign bus.alu_a       = r_aluA;
    assign bus.alu_b       = r_aluB;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: a behavioural ALU drives alu_result, and every response is
// compared against a request-level arithmetic model for directed and random requests.
module tb_alu_sequencer;

    localparam int W = 2;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    alu_sequencer_if bus ();

    alu_sequencer #(.ALU_WAIT(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU working on the packed 16-bit words: latch on negedge, compute on posedge.
    logic [2:0]  aluCmdL;
    logic [15:0] aluAL;
    logic [15:0] aluBL;
    int          aluPa;
    int          aluPb;
    int          aluTmp;

    initial begin
        aluCmdL        = 3'd0;
        aluAL          = 16'd0;
        aluBL          = 16'd0;
        bus.alu_result = 15'd0;
    end

    always @(negedge clk) begin
        aluCmdL = bus.alu_command;
        aluAL   = bus.alu_a;
        aluBL   = bus.alu_b;
    end

    always @(posedge clk) begin
        aluPa  = int'($signed(aluAL));
        aluPb  = int'($signed(aluBL));
        aluTmp = 0;
        case (aluCmdL)
            3'd0: aluTmp = (aluPa + aluPb) >>> 1;
            3'd1: aluTmp = (aluPa - aluPb) >>> 1;
            3'd2: aluTmp = (aluPa & aluPb) >>> 1;
            3'd3: aluTmp = (aluPa * aluPb) >>> 17;
            3'd4: aluTmp = (aluPa * aluPb) >>> 2;
            3'd5: aluTmp = (aluPb != 0) ? (aluPa / aluPb) : 0;
            3'd6: aluTmp = (aluPb != 0) ? ((aluPa % aluPb) >>> 1) : 0;
            default: aluTmp = 0;
        endcase
        bus.alu_result <= aluTmp[14:0];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Request-level reference: what the response words mean for each opcode.
    task automatic modelRequest(input logic [2:0] op, input logic [14:0] a, input logic [14:0] b,
                                output logic [14:0] hi, output logic [14:0] lo,
                                output logic err, output int latency);
        int sa;
        int sb;
        int v;
        int q;
        sa = int'($signed(a));
        sb = int'($signed(b));
        hi = 15'd0;
        lo = 15'd0;
        err = 1'b0;
        latency = W;
        case (op)
            3'd0: begin v = sa + sb; lo = v[14:0]; end
            3'd1: begin v = sa - sb; lo = v[14:0]; end
            3'd2: begin v = sa & sb; lo = v[14:0]; end
            3'd3: begin v = sa * sb; hi = v[29:15]; lo = v[14:0]; latency = 2 * W; end
            3'd4: begin
                if (sb == 0) begin
                    err = 1'b1;
                end else begin
                    q = sa / sb;
                    v = sa % sb;
                    hi = q[14:0];
                    lo = v[14:0];
                    latency = 2 * W;
                end
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            hi = 15'h7FFF;
            lo = 15'h7FFF;
            latency = 0;
        end
    endtask

    function automatic logic [2:0] expectCmd(input logic [2:0] op, input int phase);
        logic [2:0] c;
        case (op)
            3'd3:    c = (phase == 1) ? 3'd3 : 3'd4;
            3'd4:    c = (phase == 1) ? 3'd5 : 3'd6;
            default: c = op;
        endcase
        return c;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [14:0] a, input logic [14:0] b,
                                 input int hold);
        logic [14:0] eHi;
        logic [14:0] eLo;
        logic        eErr;
        int          eLat;
        int          cycles;
        logic [2:0]  prevCmd;
        logic [15:0] prevA;
        logic [15:0] prevB;
        logic [15:0] packA;
        logic [15:0] packB;
        logic [14:0] heldLo;

        modelRequest(op, a, b, eHi, eLo, eErr, eLat);
        packA = {a, 1'b0};
        packB = {b, 1'b0};
        @(negedge clk);
        prevCmd       = bus.alu_command;
        prevA         = bus.alu_a;
        prevB         = bus.alu_b;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.rsp_ready = (hold == 0);
        checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        if (eErr) begin
            checkOutput("err_alu_cmd_kept", 32'(bus.alu_command), 32'(prevCmd));
            checkOutput("err_alu_a_kept", 32'(bus.alu_a), 32'(prevA));
            checkOutput("err_alu_b_kept", 32'(bus.alu_b), 32'(prevB));
        end else begin
            checkOutput("cmd_phase1", 32'(bus.alu_command), 32'(expectCmd(op, 1)));
            checkOutput("alu_a_packed", 32'(bus.alu_a), 32'(packA));
            checkOutput("alu_b_packed", 32'(bus.alu_b), 32'(packB));
            checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
        end

        cycles = 0;
        while (!bus.rsp_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!eErr && cycles < W) begin
                checkOutput("cmd_phase1_stable", 32'(bus.alu_command), 32'(expectCmd(op, 1)));
            end
            if (eLat == 2 * W && cycles == W) begin
                checkOutput("cmd_phase2", 32'(bus.alu_command), 32'(expectCmd(op, 2)));
                checkOutput("alu_a_phase2", 32'(bus.alu_a), 32'(packA));
            end
        end
        checkOutput("rsp_latency", 32'(cycles), 32'(eLat));
        checkOutput("rsp_hi", 32'(bus.rsp_hi), 32'(eHi));
        checkOutput("rsp_lo", 32'(bus.rsp_lo), 32'(eLo));
        checkOutput("rsp_err", 32'(bus.rsp_err), 32'(eErr));

        heldLo = eLo;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_lo", 32'(bus.rsp_lo), 32'(heldLo));
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic applyResetMidMul();
        int sawValid;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd3;
        bus.req_a     = 15'h0123;
        bus.req_b     = 15'h0045;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("abort_cmd_issued", 32'(bus.alu_command), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("abort_alu_cmd", 32'(bus.alu_command), 32'd0);
        checkOutput("abort_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("abort_alu_b", 32'(bus.alu_b), 32'd0);
        checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("abort_rsp_hi", 32'(bus.rsp_hi), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sawValid = 0;
        for (int i = 0; i < 3 * W + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) sawValid++;
        end
        checkOutput("abort_no_response", 32'(sawValid), 32'd0);
    endtask

    initial begin
        logic [2:0]  rOp;
        logic [14:0] rA;
        logic [14:0] rB;
        checkCount    = 0;
        errorCount    = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 15'd0;
        bus.req_b     = 15'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_hi", 32'(bus.rsp_hi), 32'd0);
        checkOutput("reset_rsp_lo", 32'(bus.rsp_lo), 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("reset_alu_cmd", 32'(bus.alu_command), 32'd0);
        checkOutput("reset_alu_a", 32'(bus.alu_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'd0, 15'd5, 15'd3, 0);
        applyStimulus(3'd3, 15'h0100, 15'h0200, 0);
        applyStimulus(3'd4, 15'd17, 15'd5, 0);
        applyStimulus(3'd4, 15'd17, 15'd0, 0);
        applyStimulus(3'd6, 15'd7, 15'd9, 0);
        applyStimulus(3'd0, 15'd1, 15'd1, 0);
        applyStimulus(3'd1, 15'd9, 15'd4, 3);
        applyStimulus(3'd2, 15'h5A5A, 15'h0FF0, 1);
        applyStimulus(3'd3, 15'h7FFF, 15'h4000, 0);
        applyStimulus(3'd4, 15'h7FF0, 15'd7, 2);
        applyResetMidMul();
        applyStimulus(3'd1, 15'd0, 15'd1, 0);

        for (int n = 0; n < 40; n++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = 15'($urandom);
            rB  = ($urandom_range(0, 5) == 0) ? 15'd0 : 15'($urandom);
            applyStimulus(rOp, rA, rB, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
